// File: rtl/sysid_read_arbiter_if.sv
// Bus bundle joining the Avalon-MM read masters, the sysid read arbiter and the shared sysid slave.
// slave modport = arbiter side; master modport = everything around it (masters plus sysid slave).
interface sysid_read_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_address;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [NUM_MASTERS-1:0]        m_readdatavalid;
    logic [NUM_MASTERS*DATA_W-1:0] m_readdata;
    logic                          s_address;
    logic [DATA_W-1:0]             s_readdata;

    modport slave (
        input  m_read,
        input  m_address,
        input  s_readdata,
        output m_waitrequest,
        output m_readdatavalid,
        output m_readdata,
        output s_address
    );

    modport master (
        output m_read,
        output m_address,
        output s_readdata,
        input  m_waitrequest,
        input  m_readdatavalid,
        input  m_readdata,
        input  s_address
    );
endinterface

// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter sharing one single-address-bit sysid control slave among NUM_MASTERS readers.
// Optional SYSID_ARB_CNT_EN adds a saturating 16-bit grant_count output.
module sysid_read_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PTR_W       = 3
) (
    input  logic                clock,
    input  logic                reset,
`ifdef SYSID_ARB_CNT_EN
    output logic [15:0]         grant_count,
`endif
    sysid_read_arbiter_if.slave bus
);

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("sysid_read_arbiter: NUM_MASTERS must be 1..8");
    end
    if ((64'd1 << PTR_W) < 64'(NUM_MASTERS)) begin : g_bad_ptr_w
        $error("sysid_read_arbiter: PTR_W too narrow for NUM_MASTERS");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]              winner_q, winner_d;
    logic                          addr_q, addr_d;
    logic [DATA_W-1:0]             data_q, data_d;
    logic [NUM_MASTERS*DATA_W-1:0] rdata_q, rdata_d;

    logic                          pick_found;
    logic [PTR_W-1:0]              pick_idx;
    logic                          pick_addr;
    logic                          winner_req;
    logic [NUM_MASTERS-1:0]        resp_sel;

    // Scan from rr_ptr upward with wrap; the first requester found wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_addr  = 1'b0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!pick_found && bus.m_read[i] &&
                    (((32'(rr_ptr_q) + k) % NUM_MASTERS) == i)) begin
                    pick_found = 1'b1;
                    pick_idx   = PTR_W'(i);
                    pick_addr  = bus.m_address[i];
                end
            end
        end
    end

    always_comb begin
        winner_req = 1'b0;
        resp_sel   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (32'(winner_q) == i) begin
                winner_req  = bus.m_read[i];
                resp_sel[i] = (state_q == RESPOND);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    winner_d = pick_idx;
                    addr_d   = pick_addr;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                data_d  = bus.s_readdata;
                // A withdrawn request ends the transaction silently; the pointer is untouched.
                state_d = winner_req ? RESPOND : IDLE;
            end
            RESPOND: begin
                for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                    if (resp_sel[i]) begin
                        rdata_d[i*DATA_W +: DATA_W] = data_q;
                    end
                end
                rr_ptr_d = (32'(winner_q) == NUM_MASTERS - 1) ? '0 : winner_q + PTR_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            addr_q   <= 1'b0;
            data_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
        end
    end

    // The winner's slice shows data_q during RESPOND; rdata_q keeps every slice's last value.
    always_comb begin
        bus.m_readdata = rdata_q;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (resp_sel[i]) begin
                bus.m_readdata[i*DATA_W +: DATA_W] = data_q;
            end
        end
    end

    assign bus.m_readdatavalid = resp_sel;
    assign bus.m_waitrequest   = bus.m_read & ~resp_sel;
    assign bus.s_address       = addr_q;

`ifdef SYSID_ARB_CNT_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (state_q == RESPOND && grant_cnt_q != '1) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_count = grant_cnt_q;
`endif

    a_valid_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(bus.m_readdatavalid));
    a_respond_from_issue: assert property (@(posedge clock) disable iff (reset)
        (state_q == RESPOND) |-> $past(state_q) == ISSUE);

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Self-checking bench for sysid_read_arbiter: vector table plus corner-case sequences,
// read responses checked against a scoreboard queue of expected {master, data, cycle}.
module tb_sysid_read_arbiter;

    localparam logic [31:0] ID = 32'h50AB_1E25;

    logic clock = 1'b0;
    logic reset;
`ifdef SYSID_ARB_CNT_EN
    logic [15:0] grant_count;
`endif

    sysid_read_arbiter_if #(.NUM_MASTERS(2), .DATA_W(32)) bus ();

    assign bus.s_readdata = bus.s_address ? ID : 32'h0;

    sysid_read_arbiter #(.NUM_MASTERS(2), .DATA_W(32), .PTR_W(3)) dut (
        .clock(clock),
        .reset(reset),
`ifdef SYSID_ARB_CNT_EN
        .grant_count(grant_count),
`endif
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned who;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  addr;
        int unsigned n;
        int unsigned who0;
        logic [31:0] dat0;
        int unsigned cyc0;
        int unsigned who1;
        logic [31:0] dat1;
        int unsigned cyc1;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    logic [63:0] exp_rd;
    int unsigned cyc_cnt;
    int          n_checks;
    int          n_errors;
`ifdef SYSID_ARB_CNT_EN
    int unsigned n_done;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic push(input int unsigned who, input logic [31:0] data, input int unsigned rel);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.cyc  = cyc_cnt + rel;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t       e;
        logic [1:0] v;
        logic [1:0] oh;
        v = bus.m_readdatavalid;
        if (v != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(v), 64'(0));
            end else begin
                e  = sb.pop_front();
                oh = 2'(1 << e.who);
                exp_rd[e.who*32 +: 32] = e.data;
                check("valid_who", 64'(v), 64'(oh));
                check("valid_cycle", 64'(cyc_cnt), 64'(e.cyc));
                check("readdata", bus.m_readdata, exp_rd);
                check("waitreq_resp", 64'(bus.m_waitrequest), 64'(bus.m_read & ~oh));
`ifdef SYSID_ARB_CNT_EN
                n_done++;
`endif
            end
        end else begin
            check("readdata_hold", bus.m_readdata, exp_rd);
            check("waitreq_idle", 64'(bus.m_waitrequest), 64'(bus.m_read));
            if (sb.size() != 0 && sb[0].cyc < cyc_cnt) begin
                check("missing_valid", 64'(cyc_cnt), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
        end
    endtask

    // Starts and ends at posedge+1; masters drop read after the edge that accepted them.
    task automatic cycle(input bit sticky);
        logic [1:0] acc;
        @(negedge clock);
        monitor();
        acc = bus.m_read & ~bus.m_waitrequest;
        @(posedge clock);
        cyc_cnt++;
        #1;
        if (!sticky) bus.m_read = bus.m_read & ~acc;
    endtask

    task automatic wait_done();
        int unsigned k;
        k = 0;
        while ((sb.size() != 0 || bus.m_read != 2'b00) && k < 40) begin
            cycle(1'b0);
            k++;
        end
        if (k == 40) check("wait_timeout", 64'(sb.size()) + 64'(bus.m_read), 64'(0));
        cycle(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc_cnt  = 0;
        exp_rd   = '0;
`ifdef SYSID_ARB_CNT_EN
        n_done   = 0;
`endif
        //          req    addr   n  who0 dat0   c0 who1 dat1   c1
        vecs[0] = '{2'b10, 2'b10, 1, 1,   ID,    2, 0,   32'h0, 0};
        vecs[1] = '{2'b01, 2'b01, 1, 0,   ID,    2, 0,   32'h0, 0};
        vecs[2] = '{2'b10, 2'b00, 1, 1,   32'h0, 2, 0,   32'h0, 0};
        vecs[3] = '{2'b11, 2'b01, 2, 0,   ID,    2, 1,   32'h0, 5};
        vecs[4] = '{2'b11, 2'b10, 2, 0,   32'h0, 2, 1,   ID,    5};
        vecs[5] = '{2'b01, 2'b00, 1, 0,   32'h0, 2, 0,   32'h0, 0};
        vecs[6] = '{2'b11, 2'b11, 2, 1,   ID,    2, 0,   ID,    5};
        vecs[7] = '{2'b11, 2'b00, 2, 1,   32'h0, 2, 0,   32'h0, 5};
        vecs[8] = '{2'b10, 2'b10, 1, 1,   ID,    2, 0,   32'h0, 0};

        reset         = 1'b1;
        bus.m_read    = 2'b11;
        bus.m_address = 2'b11;
        #3;
        check("rst_valid", 64'(bus.m_readdatavalid), 64'(0));
        check("rst_readdata", bus.m_readdata, 64'(0));
        check("rst_saddr", 64'(bus.s_address), 64'(0));
        check("rst_waitreq_hi", 64'(bus.m_waitrequest), 64'(2'b11));
        bus.m_read = 2'b00;
        #1;
        check("rst_waitreq_lo", 64'(bus.m_waitrequest), 64'(2'b00));
`ifdef SYSID_ARB_CNT_EN
        check("rst_count", 64'(grant_count), 64'(0));
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(1'b0);

        foreach (vecs[j]) begin
            bus.m_address = vecs[j].addr;
            bus.m_read    = vecs[j].req;
            push(vecs[j].who0, vecs[j].dat0, vecs[j].cyc0);
            if (vecs[j].n == 2) push(vecs[j].who1, vecs[j].dat1, vecs[j].cyc1);
            wait_done();
        end

        // Continuous requests for 12 cycles from rr_ptr=0: m0, m1, m0, m1.
        bus.m_address = 2'b01;
        bus.m_read    = 2'b11;
        push(0, ID, 2);
        push(1, 32'h0, 5);
        push(0, ID, 8);
        push(1, 32'h0, 11);
        for (int i = 0; i < 12; i++) cycle(1'b1);
        bus.m_read = 2'b00;
        wait_done();

        // Reset during ISSUE with rr_ptr=1 and m1 in flight.
        bus.m_address = 2'b01;
        bus.m_read    = 2'b01;
        push(0, ID, 2);
        wait_done();
        bus.m_address = 2'b11;
        bus.m_read    = 2'b11;
        cycle(1'b0);
        #2;
        reset = 1'b1;
        #1;
        exp_rd = '0;
        check("mid_rst_valid", 64'(bus.m_readdatavalid), 64'(0));
        check("mid_rst_readdata", bus.m_readdata, 64'(0));
        check("mid_rst_saddr", 64'(bus.s_address), 64'(0));
        check("mid_rst_waitreq", 64'(bus.m_waitrequest), 64'(2'b11));
`ifdef SYSID_ARB_CNT_EN
        n_done = 0;
`endif
        cycle(1'b0);
        reset = 1'b0;
        push(0, ID, 2);
        push(1, ID, 5);
        wait_done();

        // Abort: m1 withdraws in ISSUE; pointer must stay at 1.
        bus.m_address = 2'b00;
        bus.m_read    = 2'b01;
        push(0, 32'h0, 2);
        wait_done();
        bus.m_address = 2'b00;
        bus.m_read    = 2'b10;
        cycle(1'b0);
        bus.m_read = 2'b00;
        for (int i = 0; i < 4; i++) cycle(1'b0);
        bus.m_address = 2'b01;
        bus.m_read    = 2'b11;
        push(1, 32'h0, 2);
        push(0, ID, 5);
        wait_done();

`ifdef SYSID_ARB_CNT_EN
        check("count_done", 64'(grant_count), 64'(n_done));
        force dut.grant_cnt_q = 16'hFFFF;
        #1;
        release dut.grant_cnt_q;
        bus.m_address = 2'b00;
        bus.m_read    = 2'b01;
        push(0, 32'h0, 2);
        wait_done();
        check("count_saturate", 64'(grant_count), 64'(16'hFFFF));
`endif

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
